// File: rtl/voice_pkg.sv
// rtl/voice_pkg.sv - shared widths, voice word layout and FSM encoding for the voice phase sweeper
package voice_pkg;

    localparam int NUM_VOICES = 16;
    localparam int VOICE_W    = 4;
    localparam int PHASE_W    = 24;
    localparam int INC_W      = 20;
    localparam int RAM_W      = 1 + INC_W + PHASE_W;

    // Voice word is {active, inc, phase}, MSB first
    localparam int PHASE_LSB  = 0;
    localparam int INC_LSB    = PHASE_W;
    localparam int ACT_BIT    = INC_W + PHASE_W;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SWEEP = 2'd2
    } state_e;

endpackage

// File: rtl/voice_phase_update.sv
// rtl/voice_phase_update.sv - combinational per-voice phase advance on one RAM word
module voice_phase_update
    import voice_pkg::*;
(
    input  logic [RAM_W-1:0]   word_i,
    output logic [RAM_W-1:0]   word_o,
    output logic               gate_o,
    output logic [PHASE_W-1:0] phase_o
);

    logic [INC_W-1:0]   inc;
    logic [PHASE_W-1:0] next_phase;

    // Split the word, advance the phase of gated voices (zero-extended add, carry dropped), repack
    always_comb begin
        gate_o     = word_i[ACT_BIT];
        inc        = word_i[INC_LSB +: INC_W];
        phase_o    = word_i[PHASE_LSB +: PHASE_W];
        next_phase = gate_o ? (phase_o + {{(PHASE_W - INC_W){1'b0}}, inc}) : phase_o;
        word_o     = {gate_o, inc, next_phase};
    end

endmodule

// File: rtl/voice_phase_sweeper.sv
// rtl/voice_phase_sweeper.sv - per-sample voice state sweep over the voice RAM with MIDI command writes
module voice_phase_sweeper
    import voice_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sample_tick,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [VOICE_W-1:0] cmd_voice,
    input  logic               cmd_gate,
    input  logic [INC_W-1:0]   cmd_inc,
    output logic [VOICE_W-1:0] ram_addr_a,
    output logic [RAM_W-1:0]   ram_din_a,
    output logic               ram_wr_a,
    output logic [VOICE_W-1:0] ram_addr_b,
    input  logic [RAM_W-1:0]   ram_qb,
    output logic               ph_valid,
    output logic [VOICE_W-1:0] ph_voice,
    output logic               ph_active,
    output logic [PHASE_W-1:0] ph_value,
    output logic               sweep_done,
    output logic               overrun
);

    localparam int             CNT_W      = VOICE_W + 1;
    localparam logic [CNT_W-1:0] SWEEP_LAST = CNT_W'(NUM_VOICES);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(NUM_VOICES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_prev;
    logic               overrun_q, overrun_d;
    logic               ph_valid_q, ph_valid_d;
    logic [VOICE_W-1:0] ph_voice_q, ph_voice_d;
    logic               ph_active_q, ph_active_d;
    logic [PHASE_W-1:0] ph_value_q, ph_value_d;
    logic               sweep_done_q, sweep_done_d;
    logic               wr_en;

    logic [RAM_W-1:0]   upd_word;
    logic               upd_gate;
    logic [PHASE_W-1:0] upd_phase;

    voice_phase_update u_update (
        .word_i  (ram_qb),
        .word_o  (upd_word),
        .gate_o  (upd_gate),
        .phase_o (upd_phase)
    );

    assign cnt_prev = cnt_q - CNT_ONE;

    // Next-state, counter and RAM port control; sweep cycle j reads voice j and writes back voice j-1
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        overrun_d    = overrun_q;
        ph_valid_d   = 1'b0;
        ph_voice_d   = '0;
        ph_active_d  = 1'b0;
        ph_value_d   = '0;
        sweep_done_d = 1'b0;
        wr_en        = 1'b0;
        ram_addr_a   = '0;
        ram_din_a    = '0;
        ram_addr_b   = '0;
        cmd_ready    = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                wr_en      = 1'b1;
                ram_addr_a = cnt_q[VOICE_W-1:0];
                if (cnt_q == CLEAR_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_IDLE: begin
                cmd_ready = ~sample_tick;
                if (sample_tick) begin
                    state_d = ST_SWEEP;
                    cnt_d   = '0;
                end else if (cmd_valid) begin
                    wr_en      = 1'b1;
                    ram_addr_a = cmd_voice;
                    ram_din_a  = {cmd_gate, cmd_inc, {PHASE_W{1'b0}}};
                end
            end
            ST_SWEEP: begin
                if (sample_tick) begin
                    overrun_d = 1'b1;
                end
                if (cnt_q < SWEEP_LAST) begin
                    ram_addr_b = cnt_q[VOICE_W-1:0];
                end
                if (cnt_q != '0) begin
                    wr_en       = 1'b1;
                    ram_addr_a  = cnt_prev[VOICE_W-1:0];
                    ram_din_a   = upd_word;
                    ph_valid_d  = 1'b1;
                    ph_voice_d  = cnt_prev[VOICE_W-1:0];
                    ph_active_d = upd_gate;
                    ph_value_d  = upd_phase;
                end
                if (cnt_q == SWEEP_LAST) begin
                    sweep_done_d = 1'b1;
                    state_d      = ST_IDLE;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered phase stream; reset restarts the clear pass
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_CLEAR;
            cnt_q        <= '0;
            overrun_q    <= 1'b0;
            ph_valid_q   <= 1'b0;
            ph_voice_q   <= '0;
            ph_active_q  <= 1'b0;
            ph_value_q   <= '0;
            sweep_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            overrun_q    <= overrun_d;
            ph_valid_q   <= ph_valid_d;
            ph_voice_q   <= ph_voice_d;
            ph_active_q  <= ph_active_d;
            ph_value_q   <= ph_value_d;
            sweep_done_q <= sweep_done_d;
        end
    end

    // The reset state is CLEAR, which writes; mask the strobe so it drops the moment reset asserts
    assign ram_wr_a   = wr_en & rst_n;
    assign ph_valid   = ph_valid_q;
    assign ph_voice   = ph_voice_q;
    assign ph_active  = ph_active_q;
    assign ph_value   = ph_value_q;
    assign sweep_done = sweep_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_voice_phase_sweeper.sv
// tb/tb_voice_phase_sweeper.sv - scoreboard bench for voice_phase_sweeper with a behavioural voice RAM
module tb_voice_phase_sweeper;
    import voice_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               sample_tick;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [VOICE_W-1:0] cmd_voice;
    logic               cmd_gate;
    logic [INC_W-1:0]   cmd_inc;
    logic [VOICE_W-1:0] ram_addr_a;
    logic [RAM_W-1:0]   ram_din_a;
    logic               ram_wr_a;
    logic [VOICE_W-1:0] ram_addr_b;
    logic [RAM_W-1:0]   ram_qb;
    logic               ph_valid;
    logic [VOICE_W-1:0] ph_voice;
    logic               ph_active;
    logic [PHASE_W-1:0] ph_value;
    logic               sweep_done;
    logic               overrun;

    logic [RAM_W-1:0]   mem [NUM_VOICES];
    logic               pre_we;
    logic [VOICE_W-1:0] pre_addr;
    logic [RAM_W-1:0]   pre_data;

    int cyc_cnt = 0;
    int n_cmp   = 0;
    int n_err   = 0;

    typedef struct {
        logic [VOICE_W-1:0] voice;
        logic               act;
        logic [PHASE_W-1:0] ph;
        int                 at;
        logic               done;
    } exp_t;
    exp_t sb[$];

    logic               mdl_act [NUM_VOICES];
    logic [INC_W-1:0]   mdl_inc [NUM_VOICES];
    logic [PHASE_W-1:0] mdl_ph  [NUM_VOICES];

    always #5 clk = ~clk;

    voice_phase_sweeper dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_voice   (cmd_voice),
        .cmd_gate    (cmd_gate),
        .cmd_inc     (cmd_inc),
        .ram_addr_a  (ram_addr_a),
        .ram_din_a   (ram_din_a),
        .ram_wr_a    (ram_wr_a),
        .ram_addr_b  (ram_addr_b),
        .ram_qb      (ram_qb),
        .ph_valid    (ph_valid),
        .ph_voice    (ph_voice),
        .ph_active   (ph_active),
        .ph_value    (ph_value),
        .sweep_done  (sweep_done),
        .overrun     (overrun)
    );

    // Voice RAM: port A write, port B registered read; pre_we is the bench's own back door
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (ram_wr_a) mem[ram_addr_a] <= ram_din_a;
        ram_qb <= mem[ram_addr_b];
    end

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sweep();
        exp_t e;
        for (int v = 0; v < NUM_VOICES; v++) begin
            e.voice = VOICE_W'(v);
            e.act   = mdl_act[v];
            e.ph    = mdl_ph[v];
            e.at    = cyc_cnt + 3 + v;
            e.done  = (v == NUM_VOICES - 1);
            sb.push_back(e);
            if (mdl_act[v]) mdl_ph[v] = mdl_ph[v] + {{(PHASE_W - INC_W){1'b0}}, mdl_inc[v]};
        end
    endtask

    task automatic run_sweep();
        sample_tick = 1'b1;
        push_sweep();
        cyc();
        sample_tick = 1'b0;
        repeat (NUM_VOICES + 4) cyc();
        chk("sb_drained", 64'(sb.size()), 0);
    endtask

    task automatic model_zero();
        for (int v = 0; v < NUM_VOICES; v++) begin
            mdl_act[v] = 1'b0;
            mdl_inc[v] = '0;
            mdl_ph[v]  = '0;
        end
    endtask

    // Phase stream monitor: every ph_valid pops one expected entry
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (sweep_done && !ph_valid) chk("done_without_valid", sweep_done, 0);
            if (ph_valid) begin
                if (sb.size() == 0) begin
                    chk("ph_valid_unexpected", ph_valid, 0);
                end else begin
                    e = sb.pop_front();
                    chk("ph_voice", ph_voice, e.voice);
                    chk("ph_active", ph_active, e.act);
                    chk("ph_value", ph_value, e.ph);
                    chk("ph_cycle", cyc_cnt, e.at);
                    chk("sweep_done", sweep_done, e.done);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog timeout");
    end

    initial begin
        int t0;
        int accepted;
        int wrs;
        rst_n = 1'b0; sample_tick = 1'b0; cmd_valid = 1'b0; cmd_voice = '0; cmd_gate = 1'b0; cmd_inc = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        model_zero();

        // Fill the RAM with garbage while reset is held
        for (int v = 0; v < NUM_VOICES; v++) begin
            cyc();
            pre_we   = 1'b1;
            pre_addr = VOICE_W'(v);
            pre_data = RAM_W'({$urandom(), $urandom()});
        end
        cyc();
        pre_we = 1'b0;
        #1;
        chk("rst_wr", ram_wr_a, 0);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_ph_valid", ph_valid, 0);
        chk("rst_done", sweep_done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_addr_b", ram_addr_b, 0);

        // Clear pass: 16 zero writes, a tick in the middle must be ignored
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k <= NUM_VOICES; k++) begin
            sample_tick = (k == 4);
            #1;
            if (k < NUM_VOICES) begin
                chk("clr_wr", ram_wr_a, 1);
                chk("clr_addr", ram_addr_a, k);
                chk("clr_din", ram_din_a, 0);
                chk("clr_ready", cmd_ready, 0);
                cyc();
            end else begin
                chk("idle_wr", ram_wr_a, 0);
                chk("idle_ready", cmd_ready, 1);
            end
        end
        chk("clr_no_overrun", overrun, 0);
        for (int v = 0; v < NUM_VOICES; v++) chk("clr_mem", mem[v], 0);

        // Note-on voice 3
        cmd_valid = 1'b1; cmd_voice = 4'd3; cmd_gate = 1'b1; cmd_inc = 20'h00100;
        #1;
        chk("cmd_ready", cmd_ready, 1);
        chk("cmd_wr", ram_wr_a, 1);
        chk("cmd_addr", ram_addr_a, 3);
        chk("cmd_din", ram_din_a, {1'b1, 20'h00100, 24'h000000});
        mdl_act[3] = 1'b1; mdl_inc[3] = 20'h00100; mdl_ph[3] = '0;
        cyc();
        cmd_valid = 1'b0;
        #1;
        chk("cmd_single_wr", ram_wr_a, 0);
        chk("cmd_mem", mem[3], {1'b1, 20'h00100, 24'h000000});

        run_sweep();
        run_sweep();
        run_sweep();
        chk("v3_mem_phase", mem[3][PHASE_W-1:0], 24'h000300);

        // Voice 5 preloaded near the top of the phase range
        cyc();
        pre_we = 1'b1; pre_addr = 4'd5; pre_data = {1'b1, 20'hFFFFF, 24'hFFFFF0};
        cyc();
        pre_we = 1'b0;
        mdl_act[5] = 1'b1; mdl_inc[5] = 20'hFFFFF; mdl_ph[5] = 24'hFFFFF0;
        run_sweep();
        chk("wrap_phase", mem[5][PHASE_W-1:0], 24'h0FFFEF);
        chk("wrap_inc_kept", mem[5][ACT_BIT:INC_LSB], {1'b1, 20'hFFFFF});

        // Second tick mid-sweep plus a command held across the sweep
        t0 = cyc_cnt;
        sample_tick = 1'b1;
        push_sweep();
        cyc();
        sample_tick = 1'b0;
        cmd_valid = 1'b1; cmd_voice = 4'd7; cmd_gate = 1'b1; cmd_inc = 20'h00040;
        accepted = 0;
        for (int c = 1; c < 30 && accepted == 0; c++) begin
            sample_tick = (cyc_cnt == t0 + 5);
            #1;
            if (cyc_cnt == t0 + 6) chk("overrun_set", overrun, 1);
            if (cmd_ready) begin
                accepted++;
                chk("held_cmd_cycle", cyc_cnt, t0 + 18);
                chk("held_cmd_wr", ram_wr_a, 1);
                chk("held_cmd_addr", ram_addr_a, 7);
                chk("held_cmd_din", ram_din_a, {1'b1, 20'h00040, 24'h000000});
                mdl_act[7] = 1'b1; mdl_inc[7] = 20'h00040; mdl_ph[7] = '0;
            end
            cyc();
            if (accepted != 0) cmd_valid = 1'b0;
        end
        sample_tick = 1'b0;
        #1;
        chk("held_cmd_once", accepted, 1);
        chk("held_cmd_released", ram_wr_a, 0);
        repeat (6) cyc();
        chk("no_second_sweep", 64'(sb.size()), 0);
        chk("overrun_sticky", overrun, 1);
        run_sweep();

        // Reset during sweep cycle 8
        t0 = cyc_cnt;
        sample_tick = 1'b1;
        push_sweep();
        cyc();
        sample_tick = 1'b0;
        while (cyc_cnt < t0 + 9) cyc();
        #1;
        chk("wr_mid_sweep", ram_wr_a, 1);
        rst_n = 1'b0;
        sb.delete();
        model_zero();
        #1;
        chk("wr_drop_on_reset", ram_wr_a, 0);
        chk("ph_valid_on_reset", ph_valid, 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        wrs = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (cmd_ready) break;
            if (ram_wr_a) wrs++;
            cyc();
        end
        chk("reclear_writes", wrs, NUM_VOICES);
        chk("reclear_ready", cmd_ready, 1);
        chk("reclear_overrun", overrun, 0);
        for (int v = 0; v < NUM_VOICES; v++) chk("reclear_mem", mem[v], 0);
        run_sweep();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
